reg_bank: RTL and testbench

Parametrised peripheral register bank: NREG registers of BW bits behind one address-decoded CORE-side read/write port. Each register is configured at elaboration time as one of four modes: read/write, read-only status, write-1-to-clear sticky event, or self-clearing pulse. It sits between the CORE bus and a peripheral. It drives per-register outputs, samples peripheral status and event inputs, and raises an interrupt request from pending event bits.

---
 rtl/reg_bank.sv | 118 +++++++++++
 tb/tb_reg_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: a parametrised peripheral register bank behind a single word-addressed read/write port.
// Each register has one of four modes, selected by the masks:
//   - read/write
//   - read-only, sampling datain
//   - write-1-to-clear sticky event, set by datain pulses
//   - self-clearing pulse
module reg_bank #(
  parameter int unsigned           BW         = 32,
  parameter int unsigned           NREG       = 8,
  parameter int unsigned           AW         = 3,
  parameter logic [NREG-1:0]       RO_MASK    = '0,
  parameter logic [NREG-1:0]       W1C_MASK   = '0,
  parameter logic [NREG-1:0]       PULSE_MASK = '0,
  parameter logic [NREG*BW-1:0]    RST_VAL    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        addr,
  input  logic [BW-1:0]        wdata,
  input  logic [BW/8-1:0]      wstrb,
  input  logic                 we,
  input  logic                 re,
  output logic [BW-1:0]        rdata,
  output logic                 rvalid,
  output logic                 err,
  input  logic [NREG*BW-1:0]   datain,
  output logic [NREG*BW-1:0]   dataout,
  output logic                 irq
);

  localparam int unsigned NB = BW / 8;

  logic [BW-1:0]   regs_q [NREG];
  logic [BW-1:0]   regs_d [NREG];
  logic [BW-1:0]   bmask;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] is_ro;
  logic [NREG-1:0] is_w1c;
  logic [NREG-1:0] is_pulse;
  logic            addr_ok;
  logic [BW-1:0]   rd_mux;
  logic            w1c_any;

  // Resolve overlapping masks: RO beats W1C beats PULSE beats RW
  always_comb begin
    is_ro    = RO_MASK;
    is_w1c   = W1C_MASK & ~RO_MASK;
    is_pulse = PULSE_MASK & ~W1C_MASK & ~RO_MASK;
  end

  // Expand byte strobes to a bit mask and decode the address
  always_comb begin
    bmask   = '0;
    addr_ok = (32'(addr) < NREG);
    wr_hit  = '0;
    for (int k = 0; k < int'(NB); k++) begin
      bmask[k*8 +: 8] = {8{wstrb[k]}};
    end
    for (int i = 0; i < int'(NREG); i++) begin
      wr_hit[i] = we && addr_ok && (addr == AW'(i));
    end
  end

  // Per-register next-state according to its mode
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      regs_d[i] = regs_q[i];
      if (is_ro[i]) begin
        regs_d[i] = datain[i*BW +: BW];
      end else if (is_w1c[i]) begin
        // set wins over a same-cycle clear
        regs_d[i] = (regs_q[i] & ~(wr_hit[i] ? (wdata & bmask) : '0)) | datain[i*BW +: BW];
      end else if (is_pulse[i]) begin
        regs_d[i] = wr_hit[i] ? ((RST_VAL[i*BW +: BW] & ~bmask) | (wdata & bmask))
                              : RST_VAL[i*BW +: BW];
      end else if (wr_hit[i]) begin
        regs_d[i] = (regs_q[i] & ~bmask) | (wdata & bmask);
      end
    end
  end

  // Read mux, pending-event OR and the dataout view of the register state
  always_comb begin
    rd_mux  = '0;
    w1c_any = 1'b0;
    dataout = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (addr == AW'(i)) rd_mux = regs_q[i];
      if (is_w1c[i]) w1c_any = w1c_any | (|regs_q[i]);
      dataout[i*BW +: BW] = regs_q[i];
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= RST_VAL[i*BW +: BW];
    end else begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Registered bus response and interrupt; rdata is zero whenever idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rdata  <= (re && addr_ok) ? rd_mux : '0;
      rvalid <= re;
      err    <= (we || re) && !addr_ok;
      irq    <= w1c_any;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: six registers covering every mode, plus an unmapped address.
module tb_reg_bank;

  localparam int unsigned BW   = 32;
  localparam int unsigned NREG = 6;
  localparam int unsigned AW   = 3;
  localparam logic [NREG*BW-1:0] RV = (192'hA5A5_0000 << 64);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     addr;
  logic [BW-1:0]     wdata;
  logic [BW/8-1:0]   wstrb;
  logic              we, re;
  logic [BW-1:0]     rdata;
  logic              rvalid, err, irq;
  logic [NREG*BW-1:0] datain, dataout;

  typedef struct {
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  reg_bank #(
    .BW(BW), .NREG(NREG), .AW(AW),
    .RO_MASK(6'b000010), .W1C_MASK(6'b001000), .PULSE_MASK(6'b100000),
    .RST_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .we(we), .re(re), .rdata(rdata), .rvalid(rvalid), .err(err),
    .datain(datain), .dataout(dataout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dout(input int i);
    return dataout[i*32 +: 32];
  endfunction

  // Monitor: pop an expectation whenever the DUT presents a response
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid || err) begin
        if (q.size() == 0) begin
          chk("unexpected_response", {30'd0, rvalid, err}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rvalid", {31'd0, rvalid}, {31'd0, e.rvalid});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("rdata", rdata, e.rdata);
        end
      end else begin
        chk("idle_rdata", rdata, 32'd0);
      end
    end
  end

  // One bus cycle: drive, let the edge capture it, then deassert qualifiers
  task automatic access(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    we = w; re = r; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
    exp_t e;
    e.rdata = exp; e.rvalid = 1'b1; e.err = 1'b0;
    q.push_back(e);
    access(1'b0, 1'b1, a, 32'd0, 4'h0);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    datain = '0;
    datain[1*32 +: 32] = 32'hDEAD_BEEF;
    repeat (2) step();
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_reg2", dout(2), 32'hA5A5_0000);
    chk("rst_reg1", dout(1), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ro_sample", dout(1), 32'hDEAD_BEEF);

    // Reset value readback
    rd(3'd2, 32'hA5A5_0000);

    // RW byte strobes, then read-before-write on the same address
    access(1'b1, 1'b0, 3'd0, 32'h1122_3344, 4'b0101);
    chk("rw_strb", dout(0), 32'h0022_0044);
    e.rdata = 32'h0022_0044; e.rvalid = 1'b1; e.err = 1'b0;
    q.push_back(e);
    access(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF);
    chk("rw_full", dout(0), 32'hFFFF_FFFF);

    // W1C: set from datain, irq one cycle later
    datain[3*32 + 4] = 1'b1;
    step();
    datain[3*32 + 4] = 1'b0;
    chk("w1c_set", dout(3), 32'h10);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    step();
    chk("irq_set", {31'd0, irq}, 32'd1);
    datain[3*32 + 4] = 1'b1;
    access(1'b1, 1'b0, 3'd3, 32'h10, 4'hF);
    datain[3*32 + 4] = 1'b0;
    chk("w1c_set_wins", dout(3), 32'h10);
    access(1'b1, 1'b0, 3'd3, 32'h10, 4'hF);
    chk("w1c_clr", dout(3), 32'h0);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    step();
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // PULSE: single write, then back-to-back writes; read while pulsed
    access(1'b1, 1'b0, 3'd5, 32'h1, 4'hF);
    chk("pulse_hi", dout(5), 32'h1);
    step();
    chk("pulse_lo", dout(5), 32'h0);
    access(1'b1, 1'b0, 3'd5, 32'h1, 4'hF);
    chk("pulse2_hi1", dout(5), 32'h1);
    access(1'b1, 1'b0, 3'd5, 32'h1, 4'hF);
    chk("pulse2_hi2", dout(5), 32'h1);
    rd(3'd5, 32'h1);
    chk("pulse2_lo", dout(5), 32'h0);

    // RO: writes ignored without error
    access(1'b1, 1'b0, 3'd1, 32'h0, 4'hF);
    chk("ro_keep", dout(1), 32'hDEAD_BEEF);
    rd(3'd1, 32'hDEAD_BEEF);

    // Unmapped address: error pulse, no state change
    e.rdata = 32'd0; e.rvalid = 1'b0; e.err = 1'b1;
    q.push_back(e);
    access(1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 4'hF);
    e.rvalid = 1'b1;
    q.push_back(e);
    access(1'b0, 1'b1, 3'd7, 32'd0, 4'h0);
    step();
    chk("oob_reg0", dout(0), 32'hFFFF_FFFF);
    chk("oob_reg1", dout(1), 32'hDEAD_BEEF);
    chk("oob_reg2", dout(2), 32'hA5A5_0000);
    chk("oob_reg3", dout(3), 32'h0);
    chk("oob_reg4", dout(4), 32'h0);
    chk("oob_reg5", dout(5), 32'h0);

    // Back-to-back reads, no bubble
    rd(3'd0, 32'hFFFF_FFFF);
    rd(3'd2, 32'hA5A5_0000);
    step();
    step();

    // Reset during a pending read drops the response
    chk("drained_before_reset", q.size(), 32'd0);
    re = 1'b1; addr = 3'd0; rst_n = 1'b0;
    @(posedge clk); #1;
    re = 1'b0;
    chk("rst_drop_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_reg0", dout(0), 32'd0);
    @(negedge clk);
    chk("rst_drop_rvalid_neg", {31'd0, rvalid}, 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Bounded wait for any outstanding responses
    for (int i = 0; i < 5 && q.size() != 0; i++) step();
    chk("queue_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: a hang still ends in a FAIL line
  initial begin
    #100000;
    $display("FAIL watchdog: timeout at %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
